// File: rtl/mul_pkg.sv
// Shared widths and types for the signed Wallace-tree multiplier.
package mul_pkg;

  localparam int unsigned MUL_W  = 16;
  localparam int unsigned PROD_W = 32;

  typedef logic signed [MUL_W-1:0]  op_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic [PROD_W-1:0]        row_t;

  // Baugh-Wooley correction constants: +2^MUL_W and +2^(PROD_W-1)
  localparam row_t BW_CONST = (row_t'(1) << MUL_W) | (row_t'(1) << (PROD_W - 1));

endpackage

// File: rtl/csa_3to2.sv
// Vectored 3:2 carry-save adder over full product-width rows.
module csa_3to2
  import mul_pkg::*;
(
  input  logic [PROD_W-1:0] x,
  input  logic [PROD_W-1:0] y,
  input  logic [PROD_W-1:0] z,
  output logic [PROD_W-1:0] sum,
  output logic [PROD_W-1:0] carry
);

  // Per-bit sum; majority shifted up one place, carry out of the top bit is dropped
  assign sum   = x ^ y ^ z;
  assign carry = {(x[PROD_W-2:0] & y[PROD_W-2:0]) |
                  (x[PROD_W-2:0] & z[PROD_W-2:0]) |
                  (y[PROD_W-2:0] & z[PROD_W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_multiplier.sv
// Signed 16x16 -> 32 multiplier: Baugh-Wooley partial products, Wallace
// reduction of 3:2 CSAs (16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows), final
// carry-propagate add, registered output with one-cycle latency.
module wallace_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      out_valid,
  output logic signed [2*WIDTH-1:0] product
);

  logic [MUL_W-1:0] pp [MUL_W];
  row_t l0 [16];
  row_t l1 [11];
  row_t l2 [8];
  row_t l3 [6];
  row_t l4 [4];
  row_t l5 [3];
  row_t l6 [2];
  prod_t sum_c;

  // Partial-product bits; terms mixing one sign bit with one magnitude bit are inverted
  for (genvar gi = 0; gi < MUL_W; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < MUL_W; gj++) begin : g_pp_bit
      if ((gi == MUL_W - 1) != (gj == MUL_W - 1)) begin : g_inv
        assign pp[gi][gj] = ~(a[gj] & b[gi]);
      end else begin : g_pos
        assign pp[gi][gj] = a[gj] & b[gi];
      end
    end
    // Row gi sits at weight 2^gi; row 0 also carries the correction constants in its free bits
    if (gi == 0) begin : g_row0
      assign l0[gi] = row_t'(pp[gi]) | BW_CONST;
    end else begin : g_rown
      assign l0[gi] = row_t'(pp[gi]) << gi;
    end
  end

  // Level 1: 16 -> 11
  for (genvar g = 0; g < 5; g++) begin : g_lv1
    csa_3to2 u_csa (.x(l0[3*g]), .y(l0[3*g+1]), .z(l0[3*g+2]),
                    .sum(l1[2*g]), .carry(l1[2*g+1]));
  end
  assign l1[10] = l0[15];

  // Level 2: 11 -> 8
  for (genvar g = 0; g < 3; g++) begin : g_lv2
    csa_3to2 u_csa (.x(l1[3*g]), .y(l1[3*g+1]), .z(l1[3*g+2]),
                    .sum(l2[2*g]), .carry(l2[2*g+1]));
  end
  assign l2[6] = l1[9];
  assign l2[7] = l1[10];

  // Level 3: 8 -> 6
  for (genvar g = 0; g < 2; g++) begin : g_lv3
    csa_3to2 u_csa (.x(l2[3*g]), .y(l2[3*g+1]), .z(l2[3*g+2]),
                    .sum(l3[2*g]), .carry(l3[2*g+1]));
  end
  assign l3[4] = l2[6];
  assign l3[5] = l2[7];

  // Level 4: 6 -> 4
  for (genvar g = 0; g < 2; g++) begin : g_lv4
    csa_3to2 u_csa (.x(l3[3*g]), .y(l3[3*g+1]), .z(l3[3*g+2]),
                    .sum(l4[2*g]), .carry(l4[2*g+1]));
  end

  // Level 5: 4 -> 3
  csa_3to2 u_csa_l5 (.x(l4[0]), .y(l4[1]), .z(l4[2]), .sum(l5[0]), .carry(l5[1]));
  assign l5[2] = l4[3];

  // Level 6: 3 -> 2
  csa_3to2 u_csa_l6 (.x(l5[0]), .y(l5[1]), .z(l5[2]), .sum(l6[0]), .carry(l6[1]));

  // Final carry-propagate add; carry out of the top bit is discarded
  assign sum_c = prod_t'(l6[0] + l6[1]);

  // Output register: load on valid, hold product otherwise; async reset clears both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        product <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_wallace_multiplier.sv
// Scoreboard bench for wallace_multiplier: expected products are queued when
// operands are driven and popped when the registered result is sampled.
module tb_wallace_multiplier;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               out_valid;
  logic signed [31:0] product;

  int n_checks;
  int n_fail;
  logic signed [31:0] sb_q [$];

  wallace_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus on the falling edge, queue the expectation, settle after the rising edge
  task automatic drive(input logic v, input logic signed [15:0] x, input logic signed [15:0] y,
                       input logic signed [31:0] exp_p);
    @(negedge clk);
    in_valid = v;
    a = x;
    b = y;
    if (v) sb_q.push_back(exp_p);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic signed [31:0] e;
    rst = 1'b1;
    in_valid = 1'b1;
    a = 16'sd5;
    b = 16'sd7;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (product !== 32'sd0) begin
      n_fail++;
      $display("FAIL reset_product: got %0d expected 0", product);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'sd5, 16'sd7, 32'sd35);
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || product !== e) begin
      n_fail++;
      $display("FAIL reset_release_op: got v=%b p=%0d expected v=1 p=%0d", out_valid, product, e);
    end
  endtask

  task automatic test_corners;
    int ta [7] = '{-32768, 32767, -32768, -1, 0, 1, 1234};
    int tb [7] = '{-32768, 32767, 32767, -1, -12345, -12345, -5678};
    int te [7] = '{1073741824, 1073676289, -1073709056, 1, 0, -12345, -7006652};
    logic signed [31:0] e;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 16'(ta[k]), 16'(tb[k]), 32'(te[k]));
      e = sb_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || product !== e) begin
        n_fail++;
        $display("FAIL corner_%0d: a=%0d b=%0d got v=%b p=%0d expected v=1 p=%0d",
                 k, ta[k], tb[k], out_valid, product, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic signed [31:0] e;
    // Expected values queued as literals; the pipeline drains one per edge
    @(negedge clk);
    in_valid = 1'b1; a = 16'sd2; b = 16'sd3; sb_q.push_back(32'sd6);
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || product !== e) begin
      n_fail++;
      $display("FAIL b2b_0: got v=%b p=%0d expected v=1 p=%0d", out_valid, product, e);
    end
    a = -16'sd4; b = 16'sd5; sb_q.push_back(-32'sd20);
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || product !== e) begin
      n_fail++;
      $display("FAIL b2b_1: got v=%b p=%0d expected v=1 p=%0d", out_valid, product, e);
    end
    a = 16'sd100; b = -16'sd100; sb_q.push_back(-32'sd10000);
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || product !== e) begin
      n_fail++;
      $display("FAIL b2b_2: got v=%b p=%0d expected v=1 p=%0d", out_valid, product, e);
    end
    in_valid = 1'b0; a = 16'sd77; b = 16'sd11;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || product !== -32'sd10000) begin
      n_fail++;
      $display("FAIL b2b_drop: got v=%b p=%0d expected v=0 p=-10000", out_valid, product);
    end
  endtask

  task automatic test_random;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [31:0] e;
    int bad = 0;
    for (int k = 0; k < 100; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      drive(1'b1, x, y, 32'(int'(x) * int'(y)));
      e = sb_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || product !== e) begin
        n_fail++;
        bad++;
        if (bad < 10)
          $display("FAIL random_%0d: a=%0d b=%0d got v=%b p=%0d expected v=1 p=%0d",
                   k, x, y, out_valid, product, e);
      end
    end
  endtask

  task automatic test_async_reset;
    logic signed [31:0] e;
    drive(1'b1, 16'sd300, -16'sd7, -32'sd2100);
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || product !== e) begin
      n_fail++;
      $display("FAIL async_pre: got v=%b p=%0d expected v=1 p=%0d", out_valid, product, e);
    end
    // Another op is pending in the input stage when reset hits between edges
    sb_q.push_back(32'sd81);
    a = 16'sd9; b = 16'sd9;
    #1;
    rst = 1'b1;
    #1;
    sb_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || product !== 32'sd0) begin
      n_fail++;
      $display("FAIL async_mid: got v=%b p=%0d expected v=0 p=0", out_valid, product);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || product !== 32'sd0) begin
      n_fail++;
      $display("FAIL async_after: got v=%b p=%0d expected v=0 p=0", out_valid, product);
    end
    drive(1'b1, -16'sd3, 16'sd3, -32'sd9);
    e = sb_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || product !== e) begin
      n_fail++;
      $display("FAIL async_resume: got v=%b p=%0d expected v=1 p=%0d", out_valid, product, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
